// File: rtl/pll_clken_gen.sv
// Multi-channel fractional clock-enable generator running on the PLL output clock.
// Holds the core in reset until PLL lock has been stable for LOCK_DELAY cycles.

module pll_clken_gen #(
    parameter int NUM_CH     = 3,
    parameter int ACC_W      = 16,
    parameter int LOCK_DELAY = 1024,
    parameter int DEF_NUM    = 1,
    parameter int DEF_DEN    = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic [NUM_CH-1:0] ce,
    output logic              locked,
    output logic              reset_out
);

    localparam int               CNT_W    = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DELAY - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [ACC_W-1:0] DEF_NUM_L = ACC_W'(DEF_NUM);
    localparam logic [ACC_W-1:0] DEF_DEN_L = ACC_W'(DEF_DEN);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_HOLDOFF  = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic             lk_s;
    logic             locked_q, locked_d;
    logic             reset_out_q, reset_out_d;
    logic             run_ok_s;
    logic             in_run_s;
    logic             cfg_ok_s;
    logic [ACC_W-1:0] cfg_num_c_s;

    assign lk_s      = sync_q[1];
    assign locked    = locked_q;
    assign reset_out = reset_out_q;

    // Two-flop synchroniser: the only consumer of the raw PLL lock.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    // Lock sequencing: next state and hold-off counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_UNLOCKED: begin
                cnt_d = {CNT_W{1'b0}};
                if (lk_s) begin
                    if (LOCK_DELAY == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end else begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_HOLDOFF: begin
                if (!lk_s) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Status outputs follow the next state so they move on the same edge as the FSM.
    always_comb begin
        locked_d    = (state_d == ST_RUN);
        reset_out_d = ~locked_d;
    end

    // FSM and status registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            cnt_q       <= {CNT_W{1'b0}};
            locked_q    <= 1'b0;
            reset_out_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            reset_out_q <= reset_out_d;
        end
    end

    // Accumulators only advance while staying in RUN, so entry and exit edges leave them at 0.
    always_comb begin
        in_run_s = (state_q == ST_RUN);
        run_ok_s = in_run_s && (state_d == ST_RUN);
        if (cfg_we && ({1'b0, cfg_ch} < NUM_CH_L) && (cfg_den != ACC_ZERO)) begin
            cfg_ok_s = 1'b1;
        end else begin
            cfg_ok_s = 1'b0;
        end
        if (cfg_num > cfg_den) begin
            cfg_num_c_s = cfg_den;
        end else begin
            cfg_num_c_s = cfg_num;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ACC_W-1:0] num_q, num_d;
        logic [ACC_W-1:0] den_q, den_d;
        logic [ACC_W-1:0] sh_num_q, sh_num_d;
        logic [ACC_W-1:0] sh_den_q, sh_den_d;
        logic             pend_q, pend_d;
        logic             ce_q, ce_d;
        logic [ACC_W:0]   sum_s;
        logic [ACC_W-1:0] acc_step_s;
        logic             wr_s;
        logic             xfer_s;

        assign ce[g] = ce_q;

        // Phase accumulator step plus shadowed reconfiguration at an enable boundary.
        always_comb begin
            sum_s      = {1'b0, acc_q} + {1'b0, num_q};
            ce_d       = 1'b0;
            acc_step_s = ACC_ZERO;
            wr_s       = cfg_ok_s && (cfg_ch == CH_W'(g));
            if (run_ok_s) begin
                if (sum_s >= {1'b0, den_q}) begin
                    ce_d       = 1'b1;
                    acc_step_s = sum_s[ACC_W-1:0] - den_q;
                end else begin
                    ce_d       = 1'b0;
                    acc_step_s = sum_s[ACC_W-1:0];
                end
            end else begin
                ce_d       = 1'b0;
                acc_step_s = ACC_ZERO;
            end

            // A zero numerator never produces an enable, so it must not block the update.
            xfer_s   = pend_q && (!run_ok_s || ce_d || (num_q == ACC_ZERO));
            num_d    = num_q;
            den_d    = den_q;
            sh_num_d = sh_num_q;
            sh_den_d = sh_den_q;
            pend_d   = pend_q;
            acc_d    = acc_step_s;
            if (xfer_s) begin
                num_d  = sh_num_q;
                den_d  = sh_den_q;
                pend_d = 1'b0;
                if (acc_step_s >= sh_den_q) begin
                    acc_d = ACC_ZERO;
                end else begin
                    acc_d = acc_step_s;
                end
            end else begin
                acc_d = acc_step_s;
            end

            if (wr_s) begin
                if (in_run_s) begin
                    sh_num_d = cfg_num_c_s;
                    sh_den_d = cfg_den;
                    pend_d   = 1'b1;
                end else begin
                    num_d = cfg_num_c_s;
                    den_d = cfg_den;
                end
            end else begin
                sh_num_d = sh_num_d;
            end
        end

        // Per-channel state registers.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                acc_q    <= ACC_ZERO;
                num_q    <= DEF_NUM_L;
                den_q    <= DEF_DEN_L;
                sh_num_q <= DEF_NUM_L;
                sh_den_q <= DEF_DEN_L;
                pend_q   <= 1'b0;
                ce_q     <= 1'b0;
            end else begin
                acc_q    <= acc_d;
                num_q    <= num_d;
                den_q    <= den_d;
                sh_num_q <= sh_num_d;
                sh_den_q <= sh_den_d;
                pend_q   <= pend_d;
                ce_q     <= ce_d;
            end
        end
    end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Scoreboard bench for pll_clken_gen: a behavioural model predicts {ce, locked, reset_out}
// for every edge, and directed checks cover lock timing, rates and reconfiguration.

module tb_pll_clken_gen;

    localparam int NUM_CH     = 3;
    localparam int ACC_W      = 16;
    localparam int LOCK_DELAY = 8;

    logic        refclk = 1'b0;
    logic        rst;
    logic        pll_locked;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_num;
    logic [15:0] cfg_den;
    logic [2:0]  ce;
    logic        locked;
    logic        reset_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    // model state
    bit          m_s1, m_lk, m_run;
    int          m_stable;
    int unsigned m_acc[3], m_num[3], m_den[3], m_shn[3], m_shd[3];
    bit          m_pend[3], m_ce[3];

    // enable-gap tracking on channel 0
    int cyc = 0;
    int last_ce = -1;
    int max_gap = 0;
    int last_gap = 0;
    bit gap_on = 1'b0;

    pll_clken_gen #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_DELAY(LOCK_DELAY), .DEF_NUM(1), .DEF_DEN(2)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_num(cfg_num), .cfg_den(cfg_den),
        .ce(ce), .locked(locked), .reset_out(reset_out)
    );

    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_lk = 1'b0; m_run = 1'b0; m_stable = 0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_num[i] = 1; m_den[i] = 2; m_shn[i] = 1; m_shd[i] = 2;
            m_pend[i] = 1'b0; m_ce[i] = 1'b0;
        end
    endtask

    // Predicts the outputs after the coming edge from the inputs currently applied.
    task automatic model_edge();
        bit lk_smp, run_prev, both, valid, xfer;
        int unsigned s, cn;
        lk_smp = m_lk;
        m_lk   = m_s1;
        m_s1   = pll_locked;
        run_prev = m_run;
        if (lk_smp) begin
            if (m_stable < LOCK_DELAY) m_stable++;
        end else begin
            m_stable = 0;
        end
        m_run = lk_smp && (m_stable >= LOCK_DELAY);
        both  = run_prev && m_run;
        valid = cfg_we && (cfg_ch < 2'd3) && (cfg_den != 16'd0);
        cn    = (cfg_num > cfg_den) ? cfg_den : cfg_num;
        for (int c = 0; c < 3; c++) begin
            int unsigned old_num;
            old_num = m_num[c];
            if (both) begin
                s = m_acc[c] + m_num[c];
                if (s >= m_den[c]) begin m_ce[c] = 1'b1; m_acc[c] = s - m_den[c]; end
                else begin m_ce[c] = 1'b0; m_acc[c] = s; end
            end else begin
                m_ce[c] = 1'b0; m_acc[c] = 0;
            end
            xfer = m_pend[c] && (!both || m_ce[c] || old_num == 0);
            if (xfer) begin
                m_num[c] = m_shn[c]; m_den[c] = m_shd[c]; m_pend[c] = 1'b0;
                if (m_acc[c] >= m_den[c]) m_acc[c] = 0;
            end
            if (valid && cfg_ch == c) begin
                if (run_prev) begin m_shn[c] = cn; m_shd[c] = cfg_den; m_pend[c] = 1'b1; end
                else begin m_num[c] = cn; m_den[c] = cfg_den; end
            end
        end
        exp_q.push_back({m_ce[2], m_ce[1], m_ce[0], m_run, ~m_run});
    endtask

    task automatic step();
        logic [4:0] e;
        model_edge();
        @(posedge refclk);
        #1;
        e = exp_q.pop_front();
        check_eq("outs", {ce, locked, reset_out}, e);
        cyc++;
        if (gap_on && ce[0]) begin
            if (last_ce >= 0) begin
                last_gap = cyc - last_ce;
                if (last_gap > max_gap) max_gap = last_gap;
            end
            last_ce = cyc;
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] num, input logic [15:0] den);
        cfg_we = 1'b1; cfg_ch = ch; cfg_num = num; cfg_den = den;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (reset_out == 1'b0) begin n = i; break; end
        end
    endtask

    task automatic run_cnt(input int n, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < n; i++) begin
            step();
            c0 += int'(ce[0]); c1 += int'(ce[1]); c2 += int'(ce[2]);
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_async_outs", {ce, locked, reset_out}, 5'b00001);
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n, c0, c1, c2;
        logic [7:0] pat;
        bit found;
        rst = 1'b1; pll_locked = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_num = 16'd0; cfg_den = 16'd0;
        model_reset();
        repeat (2) @(posedge refclk);
        #1;
        check_eq("reset_outs", {ce, locked, reset_out}, 5'b00001);
        @(negedge refclk);
        rst = 1'b0;

        // configuration before lock, including two writes that must be dropped
        step();
        cfg_write(2'd0, 16'd3, 16'd8);
        cfg_write(2'd1, 16'd0, 16'd7);
        cfg_write(2'd2, 16'd5, 16'd5);
        cfg_write(2'd3, 16'd1, 16'd3);
        cfg_write(2'd0, 16'd1, 16'd0);
        step();

        pll_locked = 1'b1;
        wait_run(n);
        check_eq("lock_edges", n, 10);

        c0 = 0; c1 = 0; c2 = 0; pat = 8'h00;
        for (int i = 0; i < 800; i++) begin
            step();
            if (i < 8) pat[i] = ce[0];
            c0 += int'(ce[0]); c1 += int'(ce[1]); c2 += int'(ce[2]);
        end
        check_eq("pat_3_8", pat, 8'hA4);
        check_eq("cnt_3_8", c0, 300);
        check_eq("cnt_0_7", c1, 0);
        check_eq("cnt_5_5", c2, 800);

        // 9/4 is clamped to 4/4
        cfg_write(2'd2, 16'd9, 16'd4);
        run_cnt(100, c0, c1, c2);
        check_eq("cnt_9_4", c2, 100);

        // glitch-free switch 1/4 -> 1/2 in the middle of a period
        cfg_write(2'd0, 16'd1, 16'd4);
        repeat (20) step();
        gap_on = 1'b1; last_ce = -1; max_gap = 0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ce[0]) begin found = 1'b1; break; end
        end
        check_eq("find_ce", found, 1'b1);
        step();
        cfg_write(2'd0, 16'd1, 16'd2);
        repeat (20) step();
        gap_on = 1'b0;
        check_eq("max_gap_le4", (max_gap <= 4 && max_gap >= 1), 1'b1);
        check_eq("max_gap", max_gap, 4);
        check_eq("last_gap", last_gap, 2);

        // invalid writes while running
        cfg_write(2'd3, 16'd1, 16'd1);
        cfg_write(2'd1, 16'd1, 16'd0);
        run_cnt(16, c0, c1, c2);
        check_eq("cnt_inv_ch1", c1, 0);
        check_eq("cnt_inv_ch0", c0, 8);

        // lock loss and re-lock
        pll_locked = 1'b0;
        repeat (3) step();
        check_eq("loss_outs", {ce, locked, reset_out}, 5'b00001);
        repeat (2) step();
        pll_locked = 1'b1;
        wait_run(n);
        check_eq("relock_edges", n, 10);
        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            pat[i] = ce[0];
        end
        check_eq("relock_pat_1_2", pat, 8'hAA);

        // asynchronous reset while running
        #2;
        hard_reset();

        // asynchronous reset in the middle of the hold-off
        repeat (5) step();
        #2;
        hard_reset();
        wait_run(n);
        check_eq("rst_holdoff_edges", n, 10);
        run_cnt(20, c0, c1, c2);
        check_eq("dflt_ch0", c0, 10);
        check_eq("dflt_ch1", c1, 10);
        check_eq("dflt_ch2", c2, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pll_clken_gen.md
Name: pll_clken_gen

Overview:
Parametrised multi-channel fractional clock-enable generator with lock-qualified reset sequencing. Sits directly behind the system PLL and runs on its primary output clock (49.147727 MHz in the SEGA System 1 core). Derives NUM_CH independent single-cycle enables at NUM/DEN of the clock rate, replacing extra PLL output clocks. Holds the core in reset until PLL lock has been stable for LOCK_DELAY cycles.

Parameters:
NUM_CH, 3, number of enable channels (1..16)
ACC_W, 16, width of numerator, denominator and accumulator
LOCK_DELAY, 1024, cycles of stable synchronised lock required before RUN (>=1)
DEF_NUM, 1, reset numerator for every channel
DEF_DEN, 2, reset denominator for every channel (nonzero, >= DEF_NUM)

Ports:
refclk  in  1  block clock (PLL outclk_0)
rst  in  1  asynchronous active-high reset
pll_locked  in  1  raw PLL locked, asynchronous to refclk
cfg_we  in  1  single-cycle config write strobe
cfg_ch  in  max(1,clog2(NUM_CH))  channel index for write
cfg_num  in  ACC_W  requested numerator
cfg_den  in  ACC_W  requested denominator
ce  out  NUM_CH  per-channel clock enable, one cycle wide
locked  out  1  high while state = RUN
reset_out  out  1  active-high core reset, low only in RUN

Behaviour:
- Clock/reset: one clock refclk; rst asynchronous, active-high.
- Reset values: ce=0, locked=0, reset_out=1, state=UNLOCKED, hold-off counter=0, sync flops=0, all acc=0, num=DEF_NUM, den=DEF_DEN, pending flags=0.
- Lock sync: pll_locked passes through 2 flops → lk_s. No other logic samples pll_locked.
- FSM:
  - UNLOCKED → HOLDOFF when lk_s=1; counter cleared.
  - HOLDOFF: counter increments each cycle; → RUN on the edge where counter reaches LOCK_DELAY-1.
  - Any state → UNLOCKED the cycle after lk_s=0, including from HOLDOFF (counter cleared) and RUN.
- Outputs: locked and reset_out are registered from next-state; they change on the same edge the state enters or leaves RUN.
- Outside RUN: ce=0 and all accumulators held at 0, so every channel restarts phase-aligned.
- Channel arithmetic, each RUN cycle: s = acc + num (ACC_W+1 bits).
  - If s >= den: acc <= s-den, ce[ch] <= 1.
  - Else: acc <= s, ce[ch] <= 0.
  - Edge cases: num=0 gives no enables; num=den gives ce constantly high; long-run rate is exactly num/den.
- Config writes: cfg_we with cfg_ch < NUM_CH and cfg_den != 0 is accepted; any other write is dropped silently.
  - cfg_num > cfg_den is clamped to cfg_den.
  - Not in RUN: num/den update on the next edge.
  - In RUN: the value goes to the channel's shadow with pending=1. It transfers to num/den on the first edge where that channel's ce is registered 1, or on the next edge if the current num=0. acc is not reset on transfer, but if acc >= new den then acc <= 0.
  - A second write to a pending channel overwrites the shadow.
  - A write on the same edge as a transfer: the transfer uses the old shadow and the new write becomes pending.
  - Leaving RUN applies any pending shadow immediately.
- Mid-operation rst: all state returns to reset values asynchronously; config is lost.

Test Plan:
- Reset/lock sequencing: LOCK_DELAY=8, pll_locked rises at t0 → reset_out falls and locked rises exactly 2+8 edges later; ce stays 0 before that.
- Fractional rate: ch0 num=3, den=8 written before lock → in RUN, ce[0] high on the 3rd, 6th and 8th edges after entry, pattern repeats every 8 cycles (300 enables per 800 cycles).
- Extremes: ch1 num=0 → ce[1] never high; ch2 num=den=5 → ce[2] high every RUN cycle; num=9, den=4 write → behaves as 4/4.
- Glitch-free reconfig: in RUN with ch0 at 1/4, write 1/2 mid-period → old 1/4 spacing completes, then ce[0] every 2 cycles; no enable gap above 4 or below 1 cycle.
- Lock loss: drop pll_locked mid-RUN → within 3 edges reset_out=1, locked=0, ce=0. Re-lock → full LOCK_DELAY hold-off, all channels restart from acc=0.
- Invalid writes: cfg_ch=3 with NUM_CH=3, or cfg_den=0 → num/den of all channels unchanged; async rst asserted mid-HOLDOFF → immediate return to reset values.
